rca_word_sequencer: RTL

- Multi-precision add/subtract controller that time-shares one N-bit ripple-carry adder (existing RCA module, parameter N, ports Cout, Sum, A, B, Cin) across WORDS words.
- Produces one N*WORDS-bit result.
- Latches wide operands, feeds the adder one word per cycle from LSW to MSW, and chains the carry through a register.
- Sits between a wide-operand requester and the shared narrow adder datapath.

---
 rtl/rca_word_sequencer_pkg.sv | 28 ++
 rtl/RCA.sv | 25 ++
 rtl/rca_word_sequencer.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/rca_word_sequencer_pkg.sv
// Shared definitions for the word-serial add/subtract sequencer:
// FSM encoding and the index-width helper.
package rca_word_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int width;
        int rem;
        width = 32'sd0;
        rem   = value - 32'sd1;
        while (rem > 32'sd0) begin
            width = width + 32'sd1;
            rem   = rem / 32'sd2;
        end
        return width;
    endfunction

    // A single-word configuration still needs a one-bit index register.
    function automatic int idx_width(input int words);
        return (words > 32'sd1) ? clog2(words) : 32'sd1;
    endfunction

endpackage

// File: rtl/RCA.sv
// Existing N-bit ripple-carry adder shared by the word sequencer.
// Purely combinational; port order is (Cout, Sum, A, B, Cin).
module RCA #(
    parameter int N = 4
) (
    output logic         Cout,
    output logic [N-1:0] Sum,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin
);

    // Ripple the carry bit by bit through a chain of full adders.
    always_comb begin
        logic carry_v;
        Sum     = {N{1'b0}};
        carry_v = Cin;
        for (int i = 0; i < N; i++) begin
            Sum[i]  = A[i] ^ B[i] ^ carry_v;
            carry_v = (A[i] & B[i]) | (carry_v & (A[i] ^ B[i]));
        end
        Cout = carry_v;
    end

endmodule

// File: rtl/rca_word_sequencer.sv
// Multi-precision add/subtract controller: time-shares one N-bit RCA across
// WORDS words, LSW first, chaining the carry through a register.
module rca_word_sequencer
    import rca_word_sequencer_pkg::*;
#(
    parameter int N     = 4,
    parameter int WORDS = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               sub,
    input  logic               cin,
    input  logic [N*WORDS-1:0] op_a,
    input  logic [N*WORDS-1:0] op_b,
    output logic               busy,
    output logic               done,
    output logic [N*WORDS-1:0] result,
    output logic               cout,
    output logic               ovf
);

    localparam int IDX_W = idx_width(WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    state_t                  state_r;
    state_t                  next_state_s;
    logic [IDX_W-1:0]        idx_r;
    logic                    carry_r;
    logic                    sub_r;
    logic [WORDS-1:0][N-1:0] a_reg_r;
    logic [WORDS-1:0][N-1:0] b_reg_r;
    logic [WORDS-1:0][N-1:0] result_r;
    logic                    cout_r;
    logic                    ovf_r;
    logic                    busy_r;
    logic                    done_r;

    logic                    accept_s;
    logic                    step_s;
    logic                    last_s;
    logic [N-1:0]            a_word_s;
    logic [N-1:0]            b_eff_s;
    logic [N-1:0]            rca_sum_s;
    logic                    rca_cout_s;
    logic                    ovf_s;

    // Subtraction feeds the inverted B word; the +1 comes from the seeded carry.
    assign a_word_s = a_reg_r[idx_r];
    assign b_eff_s  = b_reg_r[idx_r] ^ {N{sub_r}};
    assign ovf_s    = (a_word_s[N-1] ~^ b_eff_s[N-1]) & (rca_sum_s[N-1] ^ a_word_s[N-1]);

    RCA #(.N(N)) u_rca (
        .Cout (rca_cout_s),
        .Sum  (rca_sum_s),
        .A    (a_word_s),
        .B    (b_eff_s),
        .Cin  (carry_r)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state and datapath control decode.
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        step_s       = 1'b0;
        last_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    accept_s     = 1'b1;
                    next_state_s = RUN;
                end else begin
                    next_state_s = IDLE;
                end
            end
            RUN: begin
                step_s = 1'b1;
                if (idx_r == LAST_IDX) begin
                    last_s       = 1'b1;
                    next_state_s = DONE;
                end else begin
                    next_state_s = RUN;
                end
            end
            DONE: begin
                next_state_s = IDLE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Operand latch, word-serial accumulation and flag capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_r    <= {IDX_W{1'b0}};
            carry_r  <= 1'b0;
            sub_r    <= 1'b0;
            a_reg_r  <= {(N*WORDS){1'b0}};
            b_reg_r  <= {(N*WORDS){1'b0}};
            result_r <= {(N*WORDS){1'b0}};
            cout_r   <= 1'b0;
            ovf_r    <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            if (accept_s) begin
                a_reg_r  <= op_a;
                b_reg_r  <= op_b;
                sub_r    <= sub;
                carry_r  <= sub ? 1'b1 : cin;
                idx_r    <= {IDX_W{1'b0}};
                result_r <= {(N*WORDS){1'b0}};
            end else if (step_s) begin
                result_r[idx_r] <= rca_sum_s;
                carry_r         <= rca_cout_s;
                idx_r           <= idx_r + IDX_W'(1);
                if (last_s) begin
                    cout_r <= rca_cout_s;
                    ovf_r  <= ovf_s;
                end else begin
                    cout_r <= cout_r;
                    ovf_r  <= ovf_r;
                end
            end else begin
                idx_r <= idx_r;
            end
            // Status flags are registered from the next state so they align with it.
            busy_r <= (next_state_s != IDLE);
            done_r <= (next_state_s == DONE);
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;
    assign cout   = cout_r;
    assign ovf    = ovf_r;

endmodule
